pix_uart_tx: RTL and testbench
==============================

// Module: pix_uart_tx
// PURPOSE
//  Return path for the filtered image. Captures each pixel produced by the 3x3
//  convolution array and buffers it in a small FIFO. Serialises the pixels as
//  UART 8N1 frames back to the MATLAB host. Counts transmitted pixels and flags
//  the end of each image frame.
// PARAMETERS
//  CLKS_PER_BIT  868   clocks per UART bit (100 MHz / 115200 baud); minimum 2
//  FIFO_DEPTH    16    pixel FIFO entries; power of two
//  IMG_PIXELS    9216  pixels per frame (96x96); frame_done pulses after this many bytes
// PORTS
//  clk         in   1   system clock
//  rst         in   1   synchronous, active-high reset
//  pix_en      in   1   same enable pulse that drives the convolution array
//  pix_in      in   8   convolution output pixel; valid 1 clk after pix_en
//  tx          out  1   UART serial output; idles high
//  busy        out  1   high while a frame (start..stop) is on tx
//  fifo_full   out  1   FIFO holds FIFO_DEPTH entries
//  overflow    out  1   sticky: a pixel was dropped because the FIFO was full
//  frame_done  out  1   1-clk pulse when IMG_PIXELS bytes have been sent
//  pix_count   out  14  bytes sent in the current frame
// BEHAVIOUR
//  Clock and reset
//   - One clock, clk. rst is synchronous and active-high.
//   - rst reset values: tx=1, busy=0, fifo_full=0, overflow=0, frame_done=0, pix_count=0.
//   - rst also empties the FIFO and forces the state machine to IDLE.
//   - A frame in progress when rst is asserted is aborted; tx is high on the next clk.
//  Capture
//   - cap_en is a register set to pix_en, so cap_en is pix_en delayed one clk.
//   - When cap_en=1, pix_in is written into the FIFO on that edge.
//  FIFO
//   - Circular buffer with rd/wr pointers plus a count of width log2(FIFO_DEPTH)+1.
//   - Pointers wrap modulo FIFO_DEPTH.
//   - Write when full and no pop in the same clk: the byte is dropped, overflow is set,
//     and overflow stays set until rst.
//   - Write and pop in the same clk when full: both are performed, nothing is dropped.
//   - Write and pop in the same clk when empty: not possible, because a pop needs a
//     registered non-empty FIFO.
//   - fifo_full = (count == FIFO_DEPTH).
//  Transmit FSM (states IDLE, START, DATA, STOP)
//   - IDLE: tx=1, busy=0. If the FIFO is non-empty: pop the head into shreg, clear the
//     baud counter and bit index, go to START.
//   - START: tx=0 for CLKS_PER_BIT clks, then go to DATA.
//   - DATA: tx=shreg[bit_idx], LSB first. Each bit lasts CLKS_PER_BIT clks.
//     After bit 7 go to STOP.
//   - STOP: tx=1 for CLKS_PER_BIT clks, then return to IDLE. The byte is counted on this exit.
//   - busy=1 in START, DATA and STOP.
//   - One frame is exactly 10*CLKS_PER_BIT clks.
//   - Back-to-back frames add one IDLE clk between frames.
//  Latency
//   - FIFO empty and FSM idle, pix_en high at clk edge N: tx falls at edge N+3.
//   - Edge N+1: capture/write. Edge N+2: IDLE pops. Edge N+3: first START clk.
//  Frame counting
//   - On STOP exit: if pix_count == IMG_PIXELS-1, set pix_count=0 and pulse frame_done
//     for 1 clk. Otherwise increment pix_count by 1.
//   - frame_done does not depend on the FIFO level.
//  Arithmetic
//   - Baud counter is $clog2(CLKS_PER_BIT) bits and counts 0..CLKS_PER_BIT-1.
//   - The bit index is 3 bits. All counters are unsigned; no counter saturates.
// TESTING (bench uses CLKS_PER_BIT=4, FIFO_DEPTH=4, IMG_PIXELS=4)
//  1. One pix_en with pix_in=8'hA5. Required response:
//     - tx low 3 clks after pix_en.
//     - tx bits 0,1,0,1,0,0,1,0,1,1, each bit 4 clks.
//     - busy high for exactly 40 clks.
//     - pix_count=1.
//  2. Six pix_en on consecutive clks, bytes 01..06. Required response:
//     - 01..05 transmitted in order.
//     - 06 dropped, overflow=1, fifo_full seen high.
//     - overflow stays 1 after the FIFO drains.
//  3. FIFO full while a pop occurs and pix_en is applied in the same clk. Required response:
//     - the new byte is accepted and overflow stays 0.
//  4. Four bytes sent. Required response:
//     - frame_done pulses high for exactly 1 clk on the 4th STOP exit.
//     - pix_count returns to 0.
//     - a 5th byte gives pix_count=1.
//  5. rst asserted in DATA bit 3 with 2 bytes queued. Required response:
//     - next clk: tx=1, busy=0, fifo_full=0, pix_count=0.
//     - no further frames are sent.
//  6. pix_en held low for 1000 clks after reset. Required response:
//     - tx stays 1, busy stays 0, frame_done never pulses.

Source files
------------

// File: rtl/pix_uart_tx.sv
// rtl/pix_uart_tx.sv - pixel capture FIFO and UART 8N1 transmitter for the filtered-image return path
module pix_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16,
    parameter int IMG_PIXELS   = 9216
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    input  logic [7:0]  pix_in,
    output logic        tx,
    output logic        busy,
    output logic        fifo_full,
    output logic        overflow,
    output logic        frame_done,
    output logic [13:0] pix_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]    state;
    logic          cap_en;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [7:0]    shreg;
    logic [BW-1:0] baud;
    logic [2:0]    bit_idx;
    logic          pop;
    logic          wr_ok;
    logic          bit_end;

    assign fifo_full = (count == CW'(FIFO_DEPTH));
    // A pop needs a registered non-empty FIFO, so a same-clock write never feeds it.
    assign pop       = (state == S_IDLE) && (count != '0);
    assign wr_ok     = cap_en && (!fifo_full || pop);
    assign bit_end   = (baud == BW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= pix_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_en   <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            cap_en <= pix_en;
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (cap_en && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
            case ({wr_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            shreg      <= '0;
            baud       <= '0;
            bit_idx    <= '0;
            pix_count  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        shreg   <= mem[rd_ptr];
                        baud    <= '0;
                        bit_idx <= '0;
                        state   <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        baud  <= '0;
                        state <= S_DATA;
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                default: begin
                    if (bit_end) begin
                        baud  <= '0;
                        state <= S_IDLE;
                        if (pix_count == 14'(IMG_PIXELS - 1)) begin
                            pix_count  <= '0;
                            frame_done <= 1'b1;
                        end else begin
                            pix_count <= pix_count + 14'd1;
                        end
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
            endcase
        end
    end

    // tx and busy are registered from the state, so the line lags the FSM by one clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx   <= 1'b1;
            busy <= 1'b0;
        end else begin
            busy <= (state != S_IDLE);
            case (state)
                S_START: tx <= 1'b0;
                S_DATA:  tx <= shreg[bit_idx];
                default: tx <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_pix_uart_tx.sv
// tb/tb_pix_uart_tx.sv - randomized self-checking bench for pix_uart_tx against a timestamp-based model
module tb_pix_uart_tx;

    localparam int CB   = 4;
    localparam int FD   = 4;
    localparam int IMG  = 4;
    localparam int FLEN = 10 * CB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pix_en = 1'b0;
    logic [7:0]  pix_in = 8'h00;
    logic        tx;
    logic        busy;
    logic        fifo_full;
    logic        overflow;
    logic        frame_done;
    logic [13:0] pix_count;

    pix_uart_tx #(
        .CLKS_PER_BIT(CB),
        .FIFO_DEPTH  (FD),
        .IMG_PIXELS  (IMG)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pix_en    (pix_en),
        .pix_in    (pix_in),
        .tx        (tx),
        .busy      (busy),
        .fifo_full (fifo_full),
        .overflow  (overflow),
        .frame_done(frame_done),
        .pix_count (pix_count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Model: FIFO as a queue, transmitter as the edge number of the last pop.
    logic [7:0] q[$];
    logic [7:0] cur = 8'h00;
    int         e = 0;
    int         last_pop = -100000;
    int         next_free = 0;
    bit         cap_m = 1'b0;
    bit         ovf_m = 1'b0;
    bit         fd_m = 1'b0;
    int         cnt_m = 0;
    logic       tx_m = 1'b1;
    bit         busy_m = 1'b0;

    always @(posedge clk) begin
        int d;
        int j;
        if (rst) begin
            q.delete();
            cap_m     = 1'b0;
            ovf_m     = 1'b0;
            fd_m      = 1'b0;
            cnt_m     = 0;
            last_pop  = -100000;
            next_free = 0;
        end else begin
            fd_m = 1'b0;
            if (e == last_pop + FLEN) begin
                if (cnt_m == IMG - 1) begin
                    cnt_m = 0;
                    fd_m  = 1'b1;
                end else begin
                    cnt_m++;
                end
            end
            if (e >= next_free && q.size() > 0) begin
                cur       = q.pop_front();
                last_pop  = e;
                next_free = e + FLEN + 1;
            end
            if (cap_m) begin
                if (q.size() < FD) q.push_back(pix_in);
                else ovf_m = 1'b1;
            end
            cap_m = pix_en;
        end
        d = e - last_pop;
        if (d >= 1 && d <= FLEN) begin
            j      = (d - 1) / CB;
            busy_m = 1'b1;
            tx_m   = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : cur[j-1];
        end else begin
            busy_m = 1'b0;
            tx_m   = 1'b1;
        end
        e++;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("tx", 32'(tx), 32'(tx_m));
            check("busy", 32'(busy), 32'(busy_m));
            check("fifo_full", 32'(fifo_full), 32'(q.size() == FD));
            check("overflow", 32'(overflow), 32'(ovf_m));
            check("frame_done", 32'(frame_done), 32'(fd_m));
            check("pix_count", 32'(pix_count), 32'(cnt_m));
        end
    end

    task automatic step(input logic r, input logic en, input logic [7:0] dat);
        @(posedge clk);
        #1;
        rst    = r;
        pix_en = en;
        pix_in = dat;
    endtask

    initial begin
        repeat (3) step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        chk_en = 1'b1;

        // single byte A5
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'hA5);
        repeat (60) step(1'b0, 1'b0, 8'($urandom));

        // six consecutive pixels, the sixth overflows
        step(1'b0, 1'b1, 8'h00);
        for (int i = 1; i <= 5; i++) step(1'b0, 1'b1, 8'(i));
        step(1'b0, 1'b0, 8'h06);
        repeat (250) step(1'b0, 1'b0, 8'h00);

        // full FIFO: write lands on the pop edge
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h00);
        for (int i = 11; i <= 14; i++) step(1'b0, 1'b1, 8'(i));
        step(1'b0, 1'b0, 8'h15);
        repeat (36) step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h16);
        repeat (260) step(1'b0, 1'b0, 8'h00);

        // frame counting across IMG bytes plus one
        step(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 8'h00);
            step(1'b0, 1'b0, 8'($urandom));
            repeat (45) step(1'b0, 1'b0, 8'h00);
        end

        // reset in the middle of a frame with two bytes queued
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 8'h3C);
        step(1'b0, 1'b1, 8'hC3);
        step(1'b0, 1'b0, 8'h5A);
        repeat (14) step(1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        repeat (200) step(1'b0, 1'b0, 8'h00);

        // long idle after reset
        step(1'b1, 1'b0, 8'h00);
        repeat (1000) step(1'b0, 1'b0, 8'($urandom));

        // random traffic with bursts and rare resets
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 1499) == 0),
                 ((i % 500) < 8) || ($urandom_range(0, 29) == 0),
                 8'($urandom));
        end
        repeat (100) step(1'b0, 1'b0, 8'h00);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
